hazard_ctrl: RTL

- Control end of the pipeline-register interface for the 5-stage MIPS core.
- Consumes D-stage operand and result descriptors and keeps a shadow copy of destination register and Tnew for the E and M stages.
- Produces the stall, which drives PC hold, the D-register enable and the E-register clear, plus D-stage forwarding selects.
- Owns the mult/div busy counter and stalls HI/LO accesses while the counter is running.

---
 rtl/hazard_ctrl.sv | 132 +++++++++++++
 1 files changed

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: D-stage stall and forwarding control with E/M shadow
// of destination/Tnew, plus the mult/div busy counter.
module hazard_ctrl #(
  parameter int MULT_CYC = 5,
  parameter int DIV_CYC  = 10
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [4:0] rs_D,
  input  logic [4:0] rt_D,
  input  logic [1:0] tuse_rs,
  input  logic [1:0] tuse_rt,
  input  logic [4:0] a3_D,
  input  logic [1:0] tnew_D,
  input  logic       md_start_D,
  input  logic       md_is_div_D,
  input  logic       md_use_D,
  output logic       stall,
  output logic [1:0] fwd_rs_D,
  output logic [1:0] fwd_rt_D,
  output logic       md_busy
);

  localparam int MAXC = (DIV_CYC > MULT_CYC) ? DIV_CYC : MULT_CYC;
  localparam int CW   = $clog2(MAXC + 1);

  logic [4:0]    a3_E;
  logic [4:0]    a3_M;
  logic [1:0]    tnew_E;
  logic [1:0]    tnew_M;
  logic [CW-1:0] md_cnt;

  logic          stall_rs;
  logic          stall_rt;
  logic          stall_md;

  logic          e_rs;
  logic          m_rs;
  logic          e_rt;
  logic          m_rt;

  // A source operand is waiting on a producer that is still too young.
  function automatic logic dstall(
    input logic [4:0] r,
    input logic [1:0] t,
    input logic [4:0] ae,
    input logic [1:0] te,
    input logic [4:0] am,
    input logic [1:0] tm
  );
    return (r != 5'd0) &&
           (((ae == r) && (te > t)) ||
            ((am == r) && (tm > t)));
  endfunction

  // Stall sources: data hazards on rs/rt and HI/LO access while busy.
  always_comb begin
    stall_rs = dstall(rs_D, tuse_rs, a3_E, tnew_E,
                      a3_M, tnew_M);
    stall_rt = dstall(rt_D, tuse_rt, a3_E, tnew_E,
                      a3_M, tnew_M);
    md_busy  = (md_cnt != '0);
    stall_md = md_use_D && md_busy;
    stall    = stall_rs | stall_rt | stall_md;
  end

  // Ready results per stage; M hit is masked by E so E wins.
  always_comb begin
    e_rs = (rs_D != 5'd0) && (a3_E == rs_D) &&
           (tnew_E == 2'd0);
    m_rs = (rs_D != 5'd0) && (a3_M == rs_D) &&
           (tnew_M == 2'd0) && !e_rs;
    e_rt = (rt_D != 5'd0) && (a3_E == rt_D) &&
           (tnew_E == 2'd0);
    m_rt = (rt_D != 5'd0) && (a3_M == rt_D) &&
           (tnew_M == 2'd0) && !e_rt;
  end

  // rs forwarding select.
  always_comb begin
    fwd_rs_D = 2'd0;
    unique case (1'b1)
      e_rs:    fwd_rs_D = 2'd1;
      m_rs:    fwd_rs_D = 2'd2;
      default: fwd_rs_D = 2'd0;
    endcase
  end

  // rt forwarding select.
  always_comb begin
    fwd_rt_D = 2'd0;
    unique case (1'b1)
      e_rt:    fwd_rt_D = 2'd1;
      m_rt:    fwd_rt_D = 2'd2;
      default: fwd_rt_D = 2'd0;
    endcase
  end

  // Shadow pipe: bubble into E on stall, Tnew ages into M.
  always_ff @(posedge clk) begin
    if (reset) begin
      a3_E   <= 5'd0;
      tnew_E <= 2'd0;
      a3_M   <= 5'd0;
      tnew_M <= 2'd0;
    end else begin
      if (stall) begin
        a3_E   <= 5'd0;
        tnew_E <= 2'd0;
      end else begin
        a3_E   <= a3_D;
        tnew_E <= tnew_D;
      end
      a3_M   <= a3_E;
      tnew_M <= (tnew_E == 2'd0) ? 2'd0
                                 : tnew_E - 2'd1;
    end
  end

  // Mult/div busy counter: load on accepted start, else count down.
  always_ff @(posedge clk) begin
    if (reset) begin
      md_cnt <= '0;
    end else if (md_start_D && !stall) begin
      md_cnt <= md_is_div_D ? CW'(DIV_CYC)
                            : CW'(MULT_CYC);
    end else if (md_cnt != '0) begin
      md_cnt <= md_cnt - CW'(1);
    end
  end

endmodule
